// File: rtl/player_position_counter.sv
// Per-player race position: sync + debounce one push-button, count clean presses, saturate at finish.
// Latency: press counted DEBOUNCE_CYCLES+2 edges after btn rises; no backpressure, presses outside RACING are dropped.
module player_position_counter #(
    parameter int MAX_POS         = 109,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       is_in_menu,
    input  logic                       game_finished,
    input  logic                       btn,
    output logic [$clog2(MAX_POS)-1:0] cur_pos,
    output logic                       step_pulse,
    output logic                       at_finish,
    output logic                       frozen
);

    localparam int PW = $clog2(MAX_POS);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] FINISH_POS = PW'(MAX_POS - 1);
    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_MENU,
        ST_RACING,
        ST_FINISHED
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          db_lvl_q, db_lvl_d;
    logic          db_dly_q, db_dly_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [PW-1:0] cur_pos_q, cur_pos_d;
    logic          step_pulse_q, step_pulse_d;
    logic          press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_MENU;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            db_lvl_q     <= 1'b0;
            db_dly_q     <= 1'b0;
            dcnt_q       <= '0;
            cur_pos_q    <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            db_lvl_q     <= db_lvl_d;
            db_dly_q     <= db_dly_d;
            dcnt_q       <= dcnt_d;
            cur_pos_q    <= cur_pos_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    // Debouncer: a level change is accepted only after DEBOUNCE_CYCLES stable cycles.
    always_comb begin
        s1_d     = btn;
        s2_d     = s1_q;
        db_lvl_d = db_lvl_q;
        db_dly_d = db_lvl_q;
        dcnt_d   = dcnt_q;
        if (s2_q == db_lvl_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            db_lvl_d = s2_q;
            dcnt_d   = '0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    assign press = db_lvl_q & ~db_dly_q;

    always_comb begin
        state_d      = state_q;
        cur_pos_d    = cur_pos_q;
        step_pulse_d = 1'b0;
        if (is_in_menu) begin
            state_d   = ST_MENU;
            cur_pos_d = '0;
        end else begin
            case (state_q)
                ST_MENU: state_d = ST_RACING;
                ST_RACING: begin
                    if (game_finished) begin
                        state_d = ST_FINISHED;
                    end else if (press && (cur_pos_q < FINISH_POS)) begin
                        cur_pos_d    = cur_pos_q + PW'(1);
                        step_pulse_d = 1'b1;
                        if (cur_pos_d == FINISH_POS) state_d = ST_FINISHED;
                    end
                end
                ST_FINISHED: state_d = ST_FINISHED;
                default:     state_d = ST_MENU;
            endcase
        end
    end

    assign cur_pos    = cur_pos_q;
    assign step_pulse = step_pulse_q;
    assign at_finish  = (cur_pos_q == FINISH_POS);
    assign frozen     = (state_q == ST_FINISHED);

endmodule

// File: tb/tb_player_position_counter.sv
// Directed bench for player_position_counter with MAX_POS=5, DEBOUNCE_CYCLES=4.
module tb_player_position_counter;

    localparam int MAX_POS = 5;
    localparam int DEB     = 4;
    localparam int PW      = $clog2(MAX_POS);

    logic          clk = 1'b0;
    logic          rst;
    logic          is_in_menu;
    logic          game_finished;
    logic          btn;
    logic [PW-1:0] cur_pos;
    logic          step_pulse;
    logic          at_finish;
    logic          frozen;

    int n_checks = 0;
    int n_errors = 0;
    int steps    = 0;

    player_position_counter #(
        .MAX_POS        (MAX_POS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .is_in_menu   (is_in_menu),
        .game_finished(game_finished),
        .btn          (btn),
        .cur_pos      (cur_pos),
        .step_pulse   (step_pulse),
        .at_finish    (at_finish),
        .frozen       (frozen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Advance one edge and sample 1 time unit later; tally strobes as they appear.
    task automatic tick();
        @(posedge clk);
        #1;
        if (step_pulse) steps++;
    endtask

    // Clean press: 7 edges to the increment, snapshot there, then a full release.
    task automatic press(output logic [PW-1:0] pos7, output logic frz7, output logic stp7);
        btn = 1'b1;
        repeat (7) tick();
        pos7 = cur_pos;
        frz7 = frozen;
        stp7 = step_pulse;
        btn  = 1'b0;
        repeat (8) tick();
    endtask

    logic [PW-1:0] p;
    logic          f, s;
    int            steps_base;

    initial begin
        rst           = 1'b1;
        is_in_menu    = 1'b1;
        game_finished = 1'b0;
        btn           = 1'b0;
        repeat (3) tick();
        check("rst_pos", 32'(cur_pos), 0);
        check("rst_step", 32'(step_pulse), 0);
        check("rst_fin", 32'(at_finish), 0);
        check("rst_frz", 32'(frozen), 0);
        rst = 1'b0;
        tick();
        is_in_menu = 1'b0;
        tick();

        // Clean press: btn=1 before E0, increment lands at E6.
        steps = 0;
        btn   = 1'b1;
        repeat (6) tick();
        check("clean_pre_pos", 32'(cur_pos), 0);
        check("clean_pre_step", 32'(step_pulse), 0);
        tick();
        check("clean_pos", 32'(cur_pos), 1);
        check("clean_step_hi", 32'(step_pulse), 1);
        tick();
        check("clean_step_lo", 32'(step_pulse), 0);
        repeat (10) tick();
        check("held_pos", 32'(cur_pos), 1);
        check("held_steps", 32'(steps), 1);
        btn = 1'b0;
        repeat (8) tick();
        check("release_pos", 32'(cur_pos), 1);

        // Bounce: two-cycle pulses then a stable high.
        for (int i = 0; i < 8; i++) begin
            btn = ((i % 4) < 2);
            tick();
        end
        btn = 1'b1;
        repeat (6) tick();
        check("bounce_pre_pos", 32'(cur_pos), 1);
        tick();
        check("bounce_pos", 32'(cur_pos), 2);
        check("bounce_step", 32'(step_pulse), 1);
        btn = 1'b0;
        repeat (8) tick();
        check("bounce_steps", 32'(steps), 2);

        // External finish at position 2 freezes the counter.
        game_finished = 1'b1;
        tick();
        game_finished = 1'b0;
        check("ext_frz", 32'(frozen), 1);
        check("ext_fin", 32'(at_finish), 0);
        press(p, f, s);
        press(p, f, s);
        check("ext_hold_pos", 32'(cur_pos), 2);
        check("ext_hold_frz", 32'(frozen), 1);
        is_in_menu = 1'b1;
        tick();
        check("menu_clr_pos", 32'(cur_pos), 0);
        check("menu_clr_frz", 32'(frozen), 0);
        is_in_menu = 1'b0;
        tick();

        // Saturation: six presses, positions 1,2,3,4,4,4.
        steps = 0;
        for (int i = 1; i <= 6; i++) begin
            press(p, f, s);
            check($sformatf("sat_pos%0d", i), 32'(p), (i < 4) ? i : 4);
            check($sformatf("sat_frz%0d", i), 32'(f), (i >= 4) ? 1 : 0);
            check($sformatf("sat_step%0d", i), 32'(s), (i <= 4) ? 1 : 0);
        end
        check("sat_fin", 32'(at_finish), 1);
        check("sat_steps", 32'(steps), 4);

        // Button held across menu exit is not counted.
        is_in_menu = 1'b1;
        tick();
        btn = 1'b1;
        repeat (20) tick();
        steps_base = steps;
        is_in_menu = 1'b0;
        repeat (10) tick();
        check("heldmenu_pos", 32'(cur_pos), 0);
        check("heldmenu_steps", 32'(steps - steps_base), 0);
        btn = 1'b0;
        repeat (8) tick();
        press(p, f, s);
        check("heldmenu_press", 32'(cur_pos), 1);

        // Asynchronous reset in the middle of a debounce.
        btn = 1'b1;
        repeat (3) tick();
        #3;
        rst        = 1'b1;
        is_in_menu = 1'b1;
        #1;
        check("arst_pos", 32'(cur_pos), 0);
        check("arst_step", 32'(step_pulse), 0);
        check("arst_frz", 32'(frozen), 0);
        check("arst_db", 32'(dut.db_lvl_q), 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("arst_db_pre", 32'(dut.db_lvl_q), 0);
        tick();
        check("arst_db_up", 32'(dut.db_lvl_q), 1);
        repeat (4) tick();
        check("arst_menu_pos", 32'(cur_pos), 0);
        is_in_menu = 1'b0;
        repeat (10) tick();
        check("arst_race_pos", 32'(cur_pos), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/player_position_counter.md
# player_position_counter

Per-player race position tracker: debounces one raw push-button, counts clean presses, and drives the player's `cur_pos` bus consumed by the game-finished detector and the LED strip renderer. One instance per player (green, red, blue, yellow). It clears on menu entry and saturates at the finish cell. It freezes when any player has finished the race.

## Interface
- `MAX_POS`, 109: number of track cells; finish cell is `MAX_POS-1`.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable clock cycles required to accept a button level change (≥2).

- `clk`  in  1: system clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `is_in_menu`  in  1: high while the menu screen is shown (synchronous to `clk`).
- `game_finished`  in  1: high when any player has reached the finish cell (synchronous).
- `btn`  in  1: raw, asynchronous, bouncing push-button, active-high.
- `cur_pos`  out  $clog2(MAX_POS): current position, 0..MAX_POS-1.
- `step_pulse`  out  1: one-cycle strobe, high in the cycle after `cur_pos` advances.
- `at_finish`  out  1: `cur_pos == MAX_POS-1`, decoded from the register.
- `frozen`  out  1: high while in FINISHED state.

## Operation
- Synchronizer: two flops, `btn` → `s1` → `s2`, both reset 0.
- Debouncer: debounced level `db` (reset 0) and counter `dcnt`, width $clog2(DEBOUNCE_CYCLES+1), reset 0.
  - If `s2 == db`: `dcnt` ← 0.
  - Otherwise, if `dcnt == DEBOUNCE_CYCLES-1`: `db` ← `s2` and `dcnt` ← 0.
  - Otherwise: `dcnt` increments.
- Edge detect: `db_q` ← `db` (reset 0). `press = db & ~db_q`, active for exactly one cycle per accepted press.
- FSM states are MENU (reset state), RACING, FINISHED. Transitions in priority order:
  - `is_in_menu`=1 in any state → MENU, with `cur_pos` ← 0.
  - MENU with `is_in_menu`=0 → RACING. A press in the same cycle is ignored.
  - RACING with `game_finished`=1 → FINISHED. A press in that cycle is ignored.
  - RACING with `press`=1 and `cur_pos < MAX_POS-1` → `cur_pos`+1 and `step_pulse` ← 1.
    - If the new value is `MAX_POS-1`, next state is FINISHED.
  - FINISHED holds until `is_in_menu`=1. Presses are ignored and `cur_pos` holds.
- The debouncer and edge detector run in every state, so a button held across menu exit does not count. A new rising edge of `db` is required.
- `cur_pos` never exceeds `MAX_POS-1`. There is no wrap-around. Increment width equals the `cur_pos` width.
- `step_pulse` is 0 in every cycle where no increment occurred.

## Timing
- Reset values:
  - Outputs: `cur_pos`=0, `step_pulse`=0, `at_finish`=0, `frozen`=0.
  - Internal: state MENU, `s1`=`s2`=`db`=`db_q`=0, `dcnt`=0.
- Press latency: let E0 be the first clock edge sampling `btn`=1, with `btn` clean afterwards.
  - `s2`=1 after E1.
  - `db`=1 after E(DEBOUNCE_CYCLES+1).
  - `cur_pos` increments and `step_pulse` rises at E(DEBOUNCE_CYCLES+2).
  - `step_pulse` falls at E(DEBOUNCE_CYCLES+3).
- A glitch shorter than DEBOUNCE_CYCLES cycles at `s2` resets `dcnt` and produces no level change.
- Release follows the same latency. It produces no press.
- Menu clear: `is_in_menu` seen at edge E → `cur_pos`=0 and `frozen`=0 after E.
- `at_finish` is valid in the same cycle as `cur_pos`. `frozen` rises at the edge where FINISHED is entered.
- Mid-operation `rst` asserts the reset values immediately, independent of `clk`, and discards any partial debounce count.

## Test plan
Common settings: MAX_POS=5, DEBOUNCE_CYCLES=4.

- **Reset and clean press.** Reset, deassert `is_in_menu`, raise `btn` cleanly before edge E0.
  - `cur_pos` 0→1 at E6, `step_pulse` high for cycle E6–E7 only.
  - No further change while `btn` is held.
- **Bounce rejection.** Toggle `btn` 1,0,1,0 with 2-cycle pulses, then hold 1.
  - Exactly one increment, occurring 6 edges after the final stable rise.
- **Saturation and finish.** Apply 6 clean presses.
  - `cur_pos` sequence is 1,2,3,4, then stays at 4.
  - `at_finish`=1 and `frozen`=1 from the 4th increment.
  - Exactly 4 `step_pulse` strobes.
- **External finish freeze.** At `cur_pos`=2, pulse `game_finished` and then press twice.
  - `frozen`=1 and `cur_pos` stays 2.
  - Raising `is_in_menu` gives `cur_pos`=0 and `frozen`=0 next edge.
- **Held button across menu exit.** Hold `btn`=1 in MENU for 20 cycles, then deassert `is_in_menu`.
  - `cur_pos` stays 0.
  - Release for ≥6 cycles, then press again: `cur_pos`=1.
- **Async reset mid-debounce.** Raise `btn`, assert `rst` 3 cycles later between clock edges.
  - Outputs reach 0 before the next edge.
  - After release, the held button needs a full 6-edge latency before `db` rises. No press is counted while in MENU.
